// File: rtl/remote_comm_bridge.sv
// Host-side UART command bridge: sends a 16-bit command as two 8N1 bytes (high byte first)
// and receives single-byte responses. Optional macro REMOTE_COMM_RESP_CHECK_EN adds resp_ack/resp_nak.
module remote_comm_bridge #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
`ifdef REMOTE_COMM_RESP_CHECK_EN
    ,
    output logic        resp_ack,
    output logic        resp_nak
`endif
);

    localparam int CNT_W = ($clog2(BAUD_DIV + 1) > 12) ? $clog2(BAUD_DIV + 1) : 12;
    localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2);

    typedef enum logic [1:0] {
        IDLE,
        SEND_HI,
        SEND_LO
    } tx_state_e;

    tx_state_e        tx_state_q;
    logic [15:0]      hold_q;
    logic [9:0]       tx_shift_q;
    logic [CNT_W-1:0] tx_baud_q;
    logic [3:0]       tx_bit_q;
    logic             cmd_snt_q;

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    logic             rx_busy_q;
    logic [CNT_W-1:0] rx_baud_q;
    logic [3:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic [7:0]       resp_q;
    logic             resp_rdy_q;

    // Send sequencer and transmitter. The shift register resets to all ones so TX idles high.
    // NOTE: every register here is updated with <= so all next-state terms see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= IDLE;
            hold_q     <= '0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            cmd_snt_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    if (snd_cmd) begin
                        hold_q     <= cmd;
                        cmd_snt_q  <= 1'b0;
                        tx_shift_q <= {1'b1, cmd[15:8], 1'b0};
                        tx_baud_q  <= BAUD_LAST;
                        tx_bit_q   <= '0;
                        tx_state_q <= SEND_HI;
                    end
                end
                SEND_HI, SEND_LO: begin
                    if (tx_baud_q != '0) begin
                        tx_baud_q <= tx_baud_q - 1'b1;
                    end else if (tx_bit_q != 4'd9) begin
                        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                        tx_bit_q   <= tx_bit_q + 4'd1;
                        tx_baud_q  <= BAUD_LAST;
                    end else if (tx_state_q == SEND_HI) begin
                        // Byte swap brings the low byte into the framing position with no idle gap.
                        hold_q     <= {hold_q[7:0], hold_q[15:8]};
                        tx_shift_q <= {1'b1, hold_q[7:0], 1'b0};
                        tx_bit_q   <= '0;
                        tx_baud_q  <= BAUD_LAST;
                        tx_state_q <= SEND_LO;
                    end else begin
                        cmd_snt_q  <= 1'b1;
                        tx_state_q <= IDLE;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    // Receiver: two-flop synchronizer, mid-bit sampling from a half-bit initial count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (!rx_busy_q) begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_busy_q  <= 1'b1;
                    rx_baud_q  <= BAUD_HALF;
                    rx_bit_q   <= '0;
                    resp_rdy_q <= 1'b0;
                end
            end else if (rx_baud_q != CNT_W'(1)) begin
                rx_baud_q <= rx_baud_q - 1'b1;
            end else begin
                rx_baud_q <= BAUD_FULL;
                rx_bit_q  <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q) begin
                        rx_busy_q <= 1'b0;
                    end
                end else if (rx_bit_q != 4'd9) begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                end else begin
                    rx_busy_q <= 1'b0;
                    if (rx_sync_q) begin
                        resp_q     <= rx_shift_q;
                        resp_rdy_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign TX       = tx_shift_q[0];
    assign cmd_snt  = cmd_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

`ifdef REMOTE_COMM_RESP_CHECK_EN
    assign resp_ack = resp_rdy_q && (resp_q == 8'hA5);
    assign resp_nak = resp_rdy_q && (resp_q != 8'hA5);
`endif

endmodule

// File: tb/tb_remote_comm_bridge.sv
// Directed bench for remote_comm_bridge: table-driven TX/RX frames plus hand-written
// sequences for dropped requests, false starts, concurrent traffic and mid-frame reset.
module tb_remote_comm_bridge;

    localparam int B = 16;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        tx;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
`ifdef REMOTE_COMM_RESP_CHECK_EN
    logic        resp_ack;
    logic        resp_nak;
`endif

    int tests;
    int fails;

    remote_comm_bridge #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (rx),
        .TX       (tx),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .resp_rdy (resp_rdy),
        .resp     (resp)
`ifdef REMOTE_COMM_RESP_CHECK_EN
        ,
        .resp_ack (resp_ack),
        .resp_nak (resp_nak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [19:0] bits;   // transmitted bit order, MSB first on the wire
        int          mode;   // 0 normal, 1 extra request mid SEND_HI, 2 reset mid SEND_LO
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_rdy;
        logic [7:0] exp_resp;
    } rx_vec_t;

    // Cycle j counts from the cycle after the snd_cmd cycle; bit k is sampled mid-bit.
    task automatic tx_cmd(input logic [15:0] c, input logic [19:0] bits, input int mode);
        logic snt_low_ok;
        snt_low_ok = 1'b1;
        @(negedge clk);
        cmd     = c;
        snd_cmd = 1'b1;
        for (int j = 0; j <= 20 * B; j++) begin
            @(negedge clk);
            if (j % B == B / 2)
                check($sformatf("tx 0x%04h bit %0d", c, j / B), 32'(tx), 32'(bits[19 - j / B]));
            if (j < 20 * B && cmd_snt !== 1'b0)
                snt_low_ok = 1'b0;
            if (j == 20 * B) begin
                check($sformatf("cmd_snt rise 0x%04h", c), 32'(cmd_snt), 32'd1);
                check($sformatf("tx idle 0x%04h", c), 32'(tx), 32'd1);
            end
            if (j == 0)
                snd_cmd = 1'b0;
            if (mode == 1 && j == 5 * B) begin
                cmd     = 16'h1234;
                snd_cmd = 1'b1;
            end
            if (mode == 1 && j == 5 * B + 1)
                snd_cmd = 1'b0;
            if (mode == 2 && j == 15 * B) begin
                rst = 1'b1;
                #1;
                check("tx after mid-frame rst", 32'(tx), 32'd1);
                check("cmd_snt after mid-frame rst", 32'(cmd_snt), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        check($sformatf("cmd_snt low while sending 0x%04h", c), 32'(snt_low_ok), 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop,
                            input logic exp_rdy, input logic [7:0] exp_resp);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < B; c++) begin
                @(negedge clk);
                if (i == 1 && c == B / 2)
                    check($sformatf("rx 0x%02h rdy cleared at start", d), 32'(resp_rdy), 32'd0);
                if (i == 9 && c == 0)
                    check($sformatf("rx 0x%02h rdy not early", d), 32'(resp_rdy), 32'd0);
                if (c == 0)
                    rx = f[i];
            end
        end
        @(negedge clk);
        rx = 1'b1;
        check($sformatf("rx 0x%02h resp_rdy", d), 32'(resp_rdy), 32'(exp_rdy));
        check($sformatf("rx 0x%02h resp", d), 32'(resp), 32'(exp_resp));
`ifdef REMOTE_COMM_RESP_CHECK_EN
        check($sformatf("rx 0x%02h resp_ack", d), 32'(resp_ack), 32'(exp_rdy && exp_resp == 8'hA5));
        check($sformatf("rx 0x%02h resp_nak", d), 32'(resp_nak), 32'(exp_rdy && exp_resp != 8'hA5));
`endif
        repeat (2 * B) @(negedge clk);
    endtask

    tx_vec_t tx_vecs [3];
    rx_vec_t rx_vecs [4];

    initial begin
        tests = 0;
        fails = 0;

        tx_vecs[0] = '{cmd: 16'h0000, bits: 20'h00401, mode: 0};
        tx_vecs[1] = '{cmd: 16'h23FF, bits: 20'h625FF, mode: 0};
        tx_vecs[2] = '{cmd: 16'hABCD, bits: 20'h6AD67, mode: 1};

        rx_vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_rdy: 1'b1, exp_resp: 8'hA5};
        rx_vecs[1] = '{data: 8'h5A, stop: 1'b1, exp_rdy: 1'b1, exp_resp: 8'h5A};
        rx_vecs[2] = '{data: 8'h3C, stop: 1'b0, exp_rdy: 1'b0, exp_resp: 8'h5A};
        rx_vecs[3] = '{data: 8'hC3, stop: 1'b1, exp_rdy: 1'b1, exp_resp: 8'hC3};

        rst     = 1'b1;
        rx      = 1'b1;
        cmd     = '0;
        snd_cmd = 1'b0;
        repeat (3) @(negedge clk);
        check("reset TX", 32'(tx), 32'd1);
        check("reset cmd_snt", 32'(cmd_snt), 32'd0);
        check("reset resp_rdy", 32'(resp_rdy), 32'd0);
        check("reset resp", 32'(resp), 32'h00);
`ifdef REMOTE_COMM_RESP_CHECK_EN
        check("reset resp_ack", 32'(resp_ack), 32'd0);
        check("reset resp_nak", 32'(resp_nak), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            tx_cmd(tx_vecs[v].cmd, tx_vecs[v].bits, tx_vecs[v].mode);
            repeat (3) @(negedge clk);
            check($sformatf("cmd_snt held after 0x%04h", tx_vecs[v].cmd), 32'(cmd_snt), 32'd1);
        end

        for (int v = 0; v < 4; v++)
            rx_frame(rx_vecs[v].data, rx_vecs[v].stop, rx_vecs[v].exp_rdy, rx_vecs[v].exp_resp);

        // Short low glitch after a framing error: no response, prior byte kept.
        rx_frame(8'h69, 1'b0, 1'b0, 8'hC3);
        @(negedge clk);
        rx = 1'b0;
        repeat (B / 2 - 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("false start resp_rdy", 32'(resp_rdy), 32'd0);
        check("false start resp", 32'(resp), 32'hC3);
        rx_frame(8'h96, 1'b1, 1'b1, 8'h96);

        // Response arrives while a command is being sent.
        fork
            tx_cmd(16'h23FF, 20'h625FF, 0);
            rx_frame(8'h81, 1'b1, 1'b1, 8'h81);
        join

        // Reset halfway through SEND_LO, then a clean command.
        tx_cmd(16'hABCD, 20'h6AD67, 2);
        check("resp_rdy after rst", 32'(resp_rdy), 32'd0);
        repeat (2) @(negedge clk);
        tx_cmd(16'h1234, 20'h24459, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
